// File: rtl/clk_pkg.sv
// Shared BCD types, range constants and digit helpers for the wall-clock blocks.
package clk_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [7:0] bcd_pair_t;

    localparam bcd_pair_t MIN_MAX     = 8'h59;
    localparam bcd_pair_t HOUR_MAX_24 = 8'h23;
    localparam bcd_pair_t HOUR_MAX_12 = 8'h12;
    localparam bcd_pair_t HOUR_MIN_12 = 8'h01;

    typedef enum logic {StRun, StHold} run_state_e;

    // Both digits must be decimal; then a plain unsigned compare orders BCD correctly.
    function automatic logic bcd_in_range(bcd_pair_t v, bcd_pair_t lo, bcd_pair_t hi);
        bcd_digit_t tens;
        bcd_digit_t ones;
        tens = v[7:4];
        ones = v[3:0];
        return (tens <= 4'd9) && (ones <= 4'd9) && (v >= lo) && (v <= hi);
    endfunction

    function automatic bcd_pair_t bcd_inc(bcd_pair_t v);
        bcd_digit_t tens;
        bcd_digit_t ones;
        tens = v[7:4];
        ones = v[3:0];
        if (ones == 4'd9) begin
            return {tens + 4'd1, 4'd0};
        end
        return {tens, ones + 4'd1};
    endfunction

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD counter over [MIN_VAL, MAX_VAL] with load and a wrap indication.
module bcd_pair_counter
    import clk_pkg::*;
#(
    parameter bcd_pair_t MIN_VAL = 8'h00,
    parameter bcd_pair_t MAX_VAL = 8'h59,
    parameter bcd_pair_t RST_VAL = 8'h00
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      inc,
    input  logic      load,
    input  bcd_pair_t load_data,
    output bcd_pair_t value,
    output logic      wrap
);

    // Combinational: asserted in the cycle whose increment rolls MAX_VAL back to MIN_VAL.
    assign wrap = inc && !load && (value == MAX_VAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= RST_VAL;
        end else if (load) begin
            value <= load_data;
        end else if (inc) begin
            value <= wrap ? MIN_VAL : bcd_inc(value);
        end
    end

endmodule

// File: rtl/hm_time_counter.sv
// Hours/minutes wall-clock counter: minute-tick advance, user set/increment, hold,
// and hour/day carry pulses for the display and alarm blocks.
module hm_time_counter
    import clk_pkg::*;
#(
    parameter bit        MODE_24H = 1'b1,
    parameter bcd_pair_t RST_HOUR = 8'h00,
    parameter bcd_pair_t RST_MIN  = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       min_tick,
    input  logic       hold,
    input  logic       load,
    input  logic [7:0] set_hour,
    input  logic [7:0] set_min,
    input  logic       inc_min,
    input  logic       inc_hour,
    output logic [7:0] min_bcd,
    output logic [7:0] hour_bcd,
    output logic       pm,
    output logic       hour_tick,
    output logic       day_tick,
    output logic       load_err
);

    localparam bcd_pair_t HOUR_LO = MODE_24H ? 8'h00 : HOUR_MIN_12;
    localparam bcd_pair_t HOUR_HI = MODE_24H ? HOUR_MAX_24 : HOUR_MAX_12;

    run_state_e state_q;
    logic       tick_pend_q;
    logic       tick_pend_d;
    logic       hold_act;
    logic       load_ok;
    logic       do_load;
    logic       any_inc;
    logic       tick_apply;
    logic       min_inc;
    logic       hour_inc;
    logic       min_wrap;
    logic       hour_wrap;
    logic       carry;
    logic       day_carry;
    logic       pm_toggle;

    always_comb begin
        // Hold is honoured as soon as it rises and until the FSM has seen it fall.
        hold_act   = hold || (state_q == StHold);
        load_ok    = bcd_in_range(set_min, 8'h00, MIN_MAX) &&
                     bcd_in_range(set_hour, HOUR_LO, HOUR_HI);
        do_load    = load && load_ok;
        any_inc    = inc_min || inc_hour;
        tick_apply = !load && !any_inc && !hold_act && (min_tick || tick_pend_q);
        min_inc    = (!load && inc_min) || tick_apply;
        hour_inc   = (!load && inc_hour) || (tick_apply && min_wrap);
        carry      = tick_apply && min_wrap;
        day_carry  = MODE_24H ? (carry && hour_wrap)
                              : (carry && pm && (hour_bcd == 8'h11));
        pm_toggle  = !MODE_24H && hour_inc && (hour_bcd == 8'h11);

        tick_pend_d = 1'b0;
        if (hold_act) begin
            tick_pend_d = 1'b0;
        end else if (load) begin
            tick_pend_d = tick_pend_q && !load_ok;
        end else if (any_inc) begin
            tick_pend_d = tick_pend_q || min_tick;
        end
    end

    bcd_pair_counter #(
        .MIN_VAL(8'h00),
        .MAX_VAL(MIN_MAX),
        .RST_VAL(RST_MIN)
    ) u_min_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (min_inc),
        .load     (do_load),
        .load_data(set_min),
        .value    (min_bcd),
        .wrap     (min_wrap)
    );

    bcd_pair_counter #(
        .MIN_VAL(HOUR_LO),
        .MAX_VAL(HOUR_HI),
        .RST_VAL(RST_HOUR)
    ) u_hour_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (hour_inc),
        .load     (do_load),
        .load_data(set_hour),
        .value    (hour_bcd),
        .wrap     (hour_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            tick_pend_q <= 1'b0;
            pm          <= 1'b0;
            hour_tick   <= 1'b0;
            day_tick    <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            case (state_q)
                StRun:   if (hold)  state_q <= StHold;
                StHold:  if (!hold) state_q <= StRun;
                default: state_q <= StRun;
            endcase
            tick_pend_q <= tick_pend_d;
            if (pm_toggle) pm <= !pm;
            hour_tick   <= carry;
            day_tick    <= day_carry;
            load_err    <= load && !load_ok;
        end
    end

endmodule

// File: tb/tb_hm_time_counter.sv
// Bench for hm_time_counter: a 24-hour and a 12-hour instance share stimulus and are
// checked every cycle against a minutes/hour-of-day integer model.
module tb_hm_time_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       min_tick = 1'b0, hold = 1'b0, load = 1'b0, inc_min = 1'b0, inc_hour = 1'b0;
    logic [7:0] set_hour = 8'h00, set_min = 8'h00;

    logic [7:0] min_a, hour_a, min_b, hour_b;
    logic       pm_a, ht_a, dt_a, err_a, pm_b, ht_b, dt_b, err_b;
    logic [20:0] obs_a, obs_b;

    int checks = 0;
    int failures = 0;

    // Model: minute 0..59 and hour-of-day 0..23 per instance (index 0 = 24h, 1 = 12h).
    int mm[2];
    int hh[2];
    bit pend[2];
    bit e_ht[2], e_dt[2], e_err[2];
    bit hold_seen;

    always #5 clk = ~clk;

    assign obs_a = {min_a, hour_a, pm_a, ht_a, dt_a, err_a};
    assign obs_b = {min_b, hour_b, pm_b, ht_b, dt_b, err_b};

    hm_time_counter #(.MODE_24H(1'b1), .RST_HOUR(8'h00), .RST_MIN(8'h00)) u_a (
        .clk(clk), .rst_n(rst_n), .min_tick(min_tick), .hold(hold), .load(load),
        .set_hour(set_hour), .set_min(set_min), .inc_min(inc_min), .inc_hour(inc_hour),
        .min_bcd(min_a), .hour_bcd(hour_a), .pm(pm_a), .hour_tick(ht_a),
        .day_tick(dt_a), .load_err(err_a)
    );

    hm_time_counter #(.MODE_24H(1'b0), .RST_HOUR(8'h12), .RST_MIN(8'h00)) u_b (
        .clk(clk), .rst_n(rst_n), .min_tick(min_tick), .hold(hold), .load(load),
        .set_hour(set_hour), .set_min(set_min), .inc_min(inc_min), .inc_hour(inc_hour),
        .min_bcd(min_b), .hour_bcd(hour_b), .pm(pm_b), .hour_tick(ht_b),
        .day_tick(dt_b), .load_err(err_b)
    );

    function automatic int bcd2int(logic [7:0] v);
        if (v[3:0] > 4'd9 || v[7:4] > 4'd9) return -1;
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mm[k] = 0; hh[k] = 0; pend[k] = 0;  // 12h reset 12:00 AM is hour-of-day 0
            e_ht[k] = 0; e_dt[k] = 0; e_err[k] = 0;
        end
        hold_seen = 0;
    endtask

    task automatic model_step();
        bit hact;
        int lm, lh;
        bit ok;
        hact = hold || hold_seen;
        lm = bcd2int(set_min);
        lh = bcd2int(set_hour);
        for (int k = 0; k < 2; k++) begin
            e_ht[k] = 0; e_dt[k] = 0; e_err[k] = 0;
            if (load) begin
                ok = (lm >= 0 && lm <= 59) &&
                     ((k == 0) ? (lh >= 0 && lh <= 23) : (lh >= 1 && lh <= 12));
                if (ok) begin
                    mm[k] = lm;
                    hh[k] = (k == 0) ? lh : (lh % 12) + ((hh[k] >= 12) ? 12 : 0);
                    pend[k] = 0;
                end else begin
                    e_err[k] = 1;
                end
            end else if (inc_min || inc_hour) begin
                if (inc_min) mm[k] = (mm[k] + 1) % 60;
                if (inc_hour) hh[k] = (hh[k] + 1) % 24;
                if (min_tick && !hact) pend[k] = 1;
            end else if (!hact && (min_tick || pend[k])) begin
                pend[k] = 0;
                mm[k] = mm[k] + 1;
                if (mm[k] == 60) begin
                    mm[k] = 0;
                    e_ht[k] = 1;
                    hh[k] = (hh[k] + 1) % 24;
                    if (hh[k] == 0) e_dt[k] = 1;
                end
            end
            if (hact) pend[k] = 0;
        end
        hold_seen = hold;
    endtask

    task automatic check_model(string tag);
        logic [20:0] exp_a, exp_b;
        int h12;
        h12 = (hh[1] % 12 == 0) ? 12 : hh[1] % 12;
        exp_a = {int2bcd(mm[0]), int2bcd(hh[0]), 1'b0, e_ht[0], e_dt[0], e_err[0]};
        exp_b = {int2bcd(mm[1]), int2bcd(h12), (hh[1] >= 12), e_ht[1], e_dt[1], e_err[1]};
        checks++;
        assert (obs_a === exp_a) else begin
            failures++;
            $error("FAIL %s mode24 observed=%h expected=%h", tag, obs_a, exp_a);
        end
        checks++;
        assert (obs_b === exp_b) else begin
            failures++;
            $error("FAIL %s mode12 observed=%h expected=%h", tag, obs_b, exp_b);
        end
    endtask

    // Directed check against literal {min, hour, pm, hour_tick, day_tick, load_err}.
    task automatic expect_out(string tag, bit which, logic [7:0] m, logic [7:0] h,
                              bit p, bit ht, bit dt, bit err);
        logic [20:0] exp_v, obs_v;
        exp_v = {m, h, p, ht, dt, err};
        obs_v = which ? obs_b : obs_a;
        checks++;
        assert (obs_v === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs_v, exp_v);
        end
    endtask

    task automatic cycle(string tag);
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
        min_tick = 0; load = 0; inc_min = 0; inc_hour = 0;
    endtask

    task automatic do_load(logic [7:0] h, logic [7:0] m, string tag);
        set_hour = h; set_min = m; load = 1;
        cycle(tag);
    endtask

    initial begin
        int ht_cnt;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        expect_out("reset_a", 0, 8'h00, 8'h00, 0, 0, 0, 0);
        expect_out("reset_b", 1, 8'h00, 8'h12, 0, 0, 0, 0);
        rst_n = 1;

        ht_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            min_tick = 1;
            cycle("tick60");
            ht_cnt += int'(ht_a);
        end
        expect_out("tick60_end_a", 0, 8'h00, 8'h01, 0, 1, 0, 0);
        expect_out("tick60_end_b", 1, 8'h00, 8'h01, 0, 1, 0, 0);
        checks++;
        assert (ht_cnt == 1) else begin
            failures++;
            $error("FAIL hour_tick_count observed=%0d expected=1", ht_cnt);
        end

        do_load(8'h23, 8'h59, "load2359");
        min_tick = 1;
        cycle("day24");
        expect_out("day24_a", 0, 8'h00, 8'h00, 0, 1, 1, 0);

        do_load(8'h11, 8'h59, "load1159");
        for (int i = 0; i < 12; i++) begin
            inc_hour = 1;
            cycle("inc_hour12");
        end
        expect_out("pre_day12_b", 1, 8'h59, 8'h11, 1, 0, 0, 0);
        min_tick = 1;
        cycle("day12");
        expect_out("day12_b", 1, 8'h00, 8'h12, 0, 1, 1, 0);
        expect_out("day12_a", 0, 8'h00, 8'h00, 0, 1, 1, 0);

        do_load(8'h12, 8'h5A, "bad_min");
        expect_out("bad_min_a", 0, 8'h00, 8'h00, 0, 0, 0, 1);
        do_load(8'h24, 8'h00, "bad_hour");
        expect_out("bad_hour_a", 0, 8'h00, 8'h00, 0, 0, 0, 1);
        cycle("err_clear");
        expect_out("err_clear_a", 0, 8'h00, 8'h00, 0, 0, 0, 0);

        do_load(8'h10, 8'h15, "load1015");
        inc_min = 1; min_tick = 1;
        cycle("inc_tick");
        expect_out("inc_tick_a", 0, 8'h16, 8'h10, 0, 0, 0, 0);
        cycle("pend_apply");
        expect_out("pend_apply_a", 0, 8'h17, 8'h10, 0, 0, 0, 0);
        expect_out("pend_apply_b", 1, 8'h17, 8'h10, 0, 0, 0, 0);

        do_load(8'h08, 8'h30, "load0830");
        hold = 1;
        for (int i = 0; i < 5; i++) begin
            min_tick = 1;
            cycle("hold_tick");
        end
        expect_out("hold_a", 0, 8'h30, 8'h08, 0, 0, 0, 0);
        inc_hour = 1;
        cycle("hold_inc");
        expect_out("hold_inc_a", 0, 8'h30, 8'h09, 0, 0, 0, 0);
        hold = 0;
        cycle("hold_release");
        min_tick = 1;
        cycle("post_hold_tick");
        expect_out("post_hold_a", 0, 8'h31, 8'h09, 0, 0, 0, 0);

        min_tick = 1;
        do_load(8'h07, 8'h00, "load_tick");
        expect_out("load_tick_a", 0, 8'h00, 8'h07, 0, 0, 0, 0);
        cycle("load_tick_idle");
        expect_out("load_tick_idle_a", 0, 8'h00, 8'h07, 0, 0, 0, 0);

        do_load(8'h14, 8'h36, "load1436");
        min_tick = 1;
        cycle("to1437");
        rst_n = 0;
        #1;
        model_reset();
        check_model("async_rst");
        expect_out("async_rst_a", 0, 8'h00, 8'h00, 0, 0, 0, 0);
        expect_out("async_rst_b", 1, 8'h00, 8'h12, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        min_tick = 1;
        cycle("rst_release_tick");
        expect_out("rst_release_a", 0, 8'h01, 8'h00, 0, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(15) == 0) hold = ~hold;
            min_tick = ($urandom_range(2) == 0);
            inc_min  = ($urandom_range(7) == 0);
            inc_hour = ($urandom_range(7) == 0);
            load     = ($urandom_range(9) == 0);
            if ($urandom_range(1) == 0) begin
                set_min  = int2bcd(int'($urandom_range(59)));
                set_hour = int2bcd(int'($urandom_range(23)));
            end else begin
                set_min  = 8'($urandom);
                set_hour = 8'($urandom);
            end
            cycle("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hm_time_counter.md
Name: hm_time_counter

Overview:
- Consumes the one-pulse-per-minute tick from the minute clock generator.
- Maintains wall-clock time as BCD minutes (00-59) and hours (00-23, or 01-12 in 12-hour mode).
- Supports user time-setting: direct load, per-field increment, and a freeze/hold mode.
- Feeds the display driver and the alarm comparator downstream, which read its BCD outputs and hour/day carry pulses.

Parameters:
- MODE_24H, 1, 1 = 24-hour range 00-23; 0 = 12-hour range 01-12 with pm flag.
- RST_HOUR, 8'h00, BCD hour loaded at reset. Must be legal for the mode; use 8'h12 when MODE_24H=0.
- RST_MIN, 8'h00, BCD minute loaded at reset.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- min_tick  in  1  one-cycle pulse from the minute generator, synchronous to clk.
- hold  in  1  level; while 1, min_tick does not advance time.
- load  in  1  one-cycle pulse; load set_hour/set_min.
- set_hour  in  8  BCD hour for load.
- set_min  in  8  BCD minute for load.
- inc_min  in  1  one-cycle pulse; minute +1, no carry into hour.
- inc_hour  in  1  one-cycle pulse; hour +1 with wrap.
- min_bcd  out  8  current minute, BCD {tens[6:4], ones[3:0]}; bit 7 always 0.
- hour_bcd  out  8  current hour, BCD; bits 7:6 always 0.
- pm  out  1  12-hour mode only: 1 = PM. Tied 0 when MODE_24H=1.
- hour_tick  out  1  one-cycle pulse when a min_tick carries 59->00.
- day_tick  out  1  one-cycle pulse when a min_tick carries 23:59->00:00 (11:59 PM->12:00 AM in 12-hour mode).
- load_err  out  1  one-cycle pulse when load data is illegal; registers unchanged.

Behaviour:
- Reset (async, rst_n=0):
  - min_bcd=RST_MIN, hour_bcd=RST_HOUR, pm=0.
  - hour_tick=0, day_tick=0, load_err=0, tick_pend=0.
- All outputs are registered. An update is visible on the cycle after the causing input edge (latency 1).
- BCD arithmetic:
  - Ones digit 9->0 increments the tens digit.
  - Minute 59->00.
  - 24-hour: hour 23->00.
  - 12-hour: 12->01; 11->12 toggles pm (tick path and inc_hour path alike).
  - No binary-to-BCD conversion; digit counters only.
- Per-cycle priority: load > inc_hour/inc_min > min_tick.
  - load legal (min tens<=5, ones<=9; hour within mode range, digits<=9): fields replaced, tick_pend cleared. In 12-hour mode pm is unchanged by load.
  - load illegal: load_err=1 next cycle, time unchanged.
  - inc_hour and inc_min in the same cycle: both fields increment independently, no cross-carry.
  - A min_tick coincident with load is discarded.
  - A min_tick coincident with inc_* sets tick_pend. The pending tick is applied on the next cycle with no load/inc, so ticks are not lost to button presses.
- hold=1: min_tick and tick_pend are ignored; tick_pend is cleared on entering hold. load and inc_* still act. Releasing hold resumes on the next min_tick.
- Carry pulses:
  - hour_tick and day_tick come only from the tick path (direct or pending), never from inc_*/load.
  - day_tick implies hour_tick in the same cycle.
- State: RUN (hold=0) and HOLD (hold=1), a two-state FSM registered from hold. HOLD->RUN takes effect the cycle after hold falls.
- rst_n asserted mid-operation: immediate return to reset values. A min_tick in the release cycle is honoured normally.

Decomposition:
- Shared package clk_pkg:
  - BCD digit typedef (4 bits) and BCD pair typedef (8 bits).
  - Constants MIN_MAX=8'h59, HOUR_MAX_24=8'h23, HOUR_MAX_12=8'h12, HOUR_MIN_12=8'h01.
- One natural sub-module: bcd_pair_counter.
  - Parameters: min value, max value.
  - Inputs: inc, load, load data.
  - Outputs: value, wrap pulse.
  - Instantiated twice (minutes, hours). Top level handles priority, tick_pend, pm, and validation.

Test Plan:
- Reset with defaults, then 60 min_tick pulses -> min_bcd steps 00..59 then 00; hour_bcd=01; exactly one hour_tick, coincident with the 60th tick.
- load set_hour=8'h23, set_min=8'h59, then one min_tick -> 00:00, hour_tick=1 and day_tick=1 the same cycle. MODE_24H=0 variant: load 11:59 with pm=1, tick -> 12:00 with pm=0 and day_tick=1.
- load set_min=8'h5A, then set_hour=8'h24 -> load_err pulses once per load; time unchanged.
- inc_min and min_tick in the same cycle at 10:15 -> 10:16 next cycle, 10:17 the cycle after (pending tick); no hour_tick.
- hold=1 and 5 min_tick pulses at 08:30 -> time stays 08:30; inc_hour -> 09:30; hold=0 then one tick -> 09:31.
- min_tick coincident with a legal load of 07:00 -> 07:00, tick discarded. Assert rst_n=0 at 14:37 mid-run -> outputs reach reset values before the next clk edge.
